// File: rtl/vga_arb_pkg.sv
// Shared types and constants for the stereo VGA write arbiter.
//   MODE_*     : display mode encodings (left only, right only, side-by-side)
//   pixel_t    : one pixel record as carried through the holding registers
//   side_e     : camera side identifier used for the round-robin grant
//   norm_mode  : folds the reserved mode encoding onto side-by-side
package vga_arb_pkg;

  localparam int DATA_W  = 8;
  localparam int COORD_W = 10;

  localparam logic [1:0] MODE_LEFT  = 2'd0;
  localparam logic [1:0] MODE_RIGHT = 2'd1;
  localparam logic [1:0] MODE_SBS   = 2'd2;

  typedef struct packed {
    logic [DATA_W-1:0]  value;
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
  } pixel_t;

  typedef enum logic {
    SIDE_LEFT  = 1'b0,
    SIDE_RIGHT = 1'b1
  } side_e;

  // Encoding 3 is reserved and behaves as side-by-side.
  function automatic logic [1:0] norm_mode(input logic [1:0] m);
    return (m == 2'd3) ? MODE_SBS : m;
  endfunction

endpackage

// File: rtl/pix_hold_reg.sv
// One-entry valid/ready holding register for a camera pixel stream.
//   pclk, reset : pixel clock, asynchronous active-low reset
//   in_pix      : offered pixel; in_val offers it, in_rdy accepts it
//   sink        : side not displayed; always ready, nothing is stored
//   drop        : complete the handshake but do not store the pixel
//   flush       : discard the held entry without emitting it
//   drain       : held entry is consumed by the arbiter this cycle
//   full        : an entry is held; hold_pix is its content
//   accept      : handshake completes this cycle (in_val && in_rdy)
module pix_hold_reg
  import vga_arb_pkg::*;
(
  input  logic   pclk,
  input  logic   reset,
  input  pixel_t in_pix,
  input  logic   in_val,
  output logic   in_rdy,
  input  logic   sink,
  input  logic   drop,
  input  logic   flush,
  input  logic   drain,
  output logic   full,
  output pixel_t hold_pix,
  output logic   accept
);

  logic load;

  // Draining frees the slot in the same cycle, so a full-rate stream
  // refills on the very edge that empties it.
  assign in_rdy = sink || !full || drain;
  assign accept = in_val && in_rdy;
  assign load   = accept && !drop;

  always_ff @(posedge pclk or negedge reset) begin
    if (!reset) begin
      full <= 1'b0;
    end else if (load) begin
      full <= 1'b1;
    end else if (drain || flush) begin
      full <= 1'b0;
    end
  end

  // Pixel payload needs no reset; it is qualified by full.
  always_ff @(posedge pclk) begin
    if (load) begin
      hold_pix <= in_pix;
    end
  end

endmodule

// File: rtl/vga_write_arbiter.sv
// Shares the VGA buffer write port between the left and right camera
// pixel streams. Each side feeds a one-entry holding register; a
// round-robin arbiter drains them into a registered write stream.
//   pclk, reset          : pixel clock, asynchronous active-low reset
//   l_value/l_x/l_y      : left pixel, offered by l_val, taken on l_rdy
//   r_value/r_x/r_y      : right pixel, offered by r_val, taken on r_rdy
//   mode                 : requested display mode (0 L, 1 R, 2/3 SBS)
//   value/x/y, is_val    : registered write to the VGA buffer
//   frame_cnt            : emitted (0,0) pixels, wraps at 256
//   range_err            : sticky, an out-of-range pixel was dropped
module vga_write_arbiter
  import vga_arb_pkg::*;
#(
  parameter int IMG_W = 320,
  parameter int IMG_H = 240
) (
  input  logic               pclk,
  input  logic               reset,
  input  logic [DATA_W-1:0]  l_value,
  input  logic [COORD_W-1:0] l_x,
  input  logic [COORD_W-1:0] l_y,
  input  logic               l_val,
  output logic               l_rdy,
  input  logic [DATA_W-1:0]  r_value,
  input  logic [COORD_W-1:0] r_x,
  input  logic [COORD_W-1:0] r_y,
  input  logic               r_val,
  output logic               r_rdy,
  input  logic [1:0]         mode,
  output logic [DATA_W-1:0]  value,
  output logic [COORD_W-1:0] x,
  output logic [COORD_W-1:0] y,
  output logic               is_val,
  output logic [7:0]         frame_cnt,
  output logic               range_err
);

  localparam logic [COORD_W-1:0] IMG_W_C = COORD_W'(IMG_W);
  localparam logic [COORD_W-1:0] IMG_H_C = COORD_W'(IMG_H);

  logic [1:0] mode_q;
  logic [1:0] mode_eff;
  side_e      last_grant;

  pixel_t l_in, r_in, l_hold, r_hold, out_nxt;
  logic   l_full, r_full;
  logic   l_acc, r_acc;
  logic   l_sel_q, r_sel_q, l_sel, r_sel;
  logic   l_zero, r_zero, l_bad, r_bad;
  logic   l_drop, r_drop, l_flush, r_flush;
  logic   mode_load, mode_chg;
  logic   grant_l, grant_r, emit_l, emit_r, emit;
  logic [COORD_W-1:0] r_x_map;

  assign l_in = {l_value, l_x, l_y};
  assign r_in = {r_value, r_x, r_y};

  // Sides hidden by the registered mode are sunk: always ready, never stored.
  assign l_sel_q = (mode_q != MODE_RIGHT);
  assign r_sel_q = (mode_q != MODE_LEFT);

  // Round-robin on the held entries; ties go to the side not served last.
  always_comb begin
    grant_l = 1'b0;
    grant_r = 1'b0;
    if (l_full && r_full) begin
      if (last_grant == SIDE_RIGHT) grant_l = 1'b1;
      else                          grant_r = 1'b1;
    end else if (l_full) begin
      grant_l = 1'b1;
    end else if (r_full) begin
      grant_r = 1'b1;
    end
  end

  // A (0,0) pixel accepted from the primary side latches the requested
  // mode, and that pixel is already handled under the new mode.
  assign l_zero    = (l_x == '0) && (l_y == '0);
  assign r_zero    = (r_x == '0) && (r_y == '0);
  assign mode_load = (mode_q == MODE_RIGHT) ? (r_acc && r_zero) : (l_acc && l_zero);
  assign mode_eff  = mode_load ? norm_mode(mode) : mode_q;
  assign mode_chg  = (mode_eff != mode_q);

  assign l_sel   = (mode_eff != MODE_RIGHT);
  assign r_sel   = (mode_eff != MODE_LEFT);
  assign l_flush = mode_chg && !l_sel;
  assign r_flush = mode_chg && !r_sel;

  assign l_bad  = (l_x >= IMG_W_C) || (l_y >= IMG_H_C);
  assign r_bad  = (r_x >= IMG_W_C) || (r_y >= IMG_H_C);
  assign l_drop = !l_sel || l_bad;
  assign r_drop = !r_sel || r_bad;

  pix_hold_reg u_l_hold (
    .pclk     (pclk),
    .reset    (reset),
    .in_pix   (l_in),
    .in_val   (l_val),
    .in_rdy   (l_rdy),
    .sink     (!l_sel_q),
    .drop     (l_drop),
    .flush    (l_flush),
    .drain    (grant_l),
    .full     (l_full),
    .hold_pix (l_hold),
    .accept   (l_acc)
  );

  pix_hold_reg u_r_hold (
    .pclk     (pclk),
    .reset    (reset),
    .in_pix   (r_in),
    .in_val   (r_val),
    .in_rdy   (r_rdy),
    .sink     (!r_sel_q),
    .drop     (r_drop),
    .flush    (r_flush),
    .drain    (grant_r),
    .full     (r_full),
    .hold_pix (r_hold),
    .accept   (r_acc)
  );

  // A granted entry that is flushed by a mode change leaves its register
  // but never reaches the display.
  assign emit_l = grant_l && !l_flush;
  assign emit_r = grant_r && !r_flush;
  assign emit   = emit_l || emit_r;

  // Right image lands in the right half only in side-by-side mode.
  assign r_x_map = (mode_q == MODE_SBS) ? (r_hold.x + IMG_W_C) : r_hold.x;

  always_comb begin
    out_nxt = l_hold;
    if (emit_r) begin
      out_nxt   = r_hold;
      out_nxt.x = r_x_map;
    end
  end

  // ---- output register stage ----
  always_ff @(posedge pclk or negedge reset) begin
    if (!reset) begin
      is_val     <= 1'b0;
      value      <= '0;
      x          <= '0;
      y          <= '0;
      frame_cnt  <= '0;
      range_err  <= 1'b0;
      mode_q     <= MODE_SBS;
      last_grant <= SIDE_RIGHT;
    end else begin
      is_val <= emit;
      mode_q <= mode_eff;
      if (emit) begin
        value      <= out_nxt.value;
        x          <= out_nxt.x;
        y          <= out_nxt.y;
        last_grant <= emit_l ? SIDE_LEFT : SIDE_RIGHT;
        if ((out_nxt.x == '0) && (out_nxt.y == '0)) begin
          frame_cnt <= frame_cnt + 8'd1;
        end
      end
      if ((l_acc && l_sel && l_bad) || (r_acc && r_sel && r_bad)) begin
        range_err <= 1'b1;
      end
    end
  end

endmodule
